// File: rtl/control_mult_der_izq_pkg.sv
// -----------------------------------------------------------------------------
// control_mult_der_izq_pkg
//   Shared definitions for the right-to-left shift-and-add multiplier.
//   - estado_t   : FSM state encoding (REPOSO / PASO / FIN).
//   - K_DEFAULT  : default operand width in bits.
//   - ancho_cnt  : width of the step counter for a given operand width.
// -----------------------------------------------------------------------------
package control_mult_der_izq_pkg;

  localparam int K_DEFAULT = 4;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    PASO   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  // The counter has to hold 0..K-1; one extra bit keeps it safe for
  // widths that are exact powers of two.
  function automatic int ancho_cnt(input int k);
    return $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/control_mult_der_izq_camino_datos.sv
// -----------------------------------------------------------------------------
// camino_datos_der_izq
//   Datapath of the shift-and-add multiplier. The multiplier register is
//   consumed from its LSB while the zero-extended multiplicand moves left, so
//   each step adds the correctly weighted partial product to the accumulator.
//
//   Ports
//     clk, reset          : clock and asynchronous active-high reset
//     cargar              : capture operands, clear accumulator
//     paso                : perform one add/shift step
//     guardar             : load producto from the result of this step
//     a_valor [K-1:0]     : multiplicand
//     b_valor [K-1:0]     : multiplier
//     producto [2K-1:0]   : registered result, held between loads
// -----------------------------------------------------------------------------
module camino_datos_der_izq
  import control_mult_der_izq_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cargar,
  input  logic           paso,
  input  logic           guardar,
  input  logic [K-1:0]   a_valor,
  input  logic [K-1:0]   b_valor,
  output logic [2*K-1:0] producto
);

  logic [2*K-1:0] multiplicando;
  logic [K-1:0]   multiplicador;
  logic [2*K-1:0] acumulador;
  logic [2*K-1:0] suma;

  // 2K bits always suffice: the largest product is (2^K-1)^2 < 2^(2K).
  always_comb begin
    suma = acumulador;
    if (multiplicador[0]) begin
      suma = acumulador + multiplicando;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multiplicando <= '0;
      multiplicador <= '0;
      acumulador    <= '0;
    end else if (cargar) begin
      multiplicando <= {{K{1'b0}}, a_valor};
      multiplicador <= b_valor;
      acumulador    <= '0;
    end else if (paso) begin
      acumulador    <= suma;
      multiplicando <= multiplicando << 1;
      multiplicador <= multiplicador >> 1;
    end
  end

  // The final step's sum is taken directly so producto is ready in FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      producto <= '0;
    end else if (guardar) begin
      producto <= suma;
    end
  end

endmodule

// File: rtl/control_mult_der_izq.sv
// -----------------------------------------------------------------------------
// control_mult_der_izq
//   Sequential unsigned K x K multiplier. A request accepted in REPOSO runs
//   exactly K PASO cycles followed by one FIN cycle, in which valido pulses
//   and producto already holds the new result.
//
//   Ports
//     clk                 : clock, rising edge
//     reset               : asynchronous active-high reset
//     inicio              : start request, sampled only while listo=1
//     A_valor [K-1:0]     : multiplicand, captured on the accepting edge
//     B_valor [K-1:0]     : multiplier, captured on the accepting edge
//     listo               : ready (state REPOSO)
//     ocupado             : busy (states PASO and FIN)
//     valido              : one-cycle result strobe (state FIN)
//     producto [2K-1:0]   : result, held until the next FIN
// -----------------------------------------------------------------------------
module control_mult_der_izq
  import control_mult_der_izq_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inicio,
  input  logic [K-1:0]   A_valor,
  input  logic [K-1:0]   B_valor,
  output logic           listo,
  output logic           ocupado,
  output logic           valido,
  output logic [2*K-1:0] producto
);

  localparam int                CNT_W  = ancho_cnt(K);
  localparam logic [CNT_W-1:0]  ULTIMO = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0]  UNO    = CNT_W'(1);

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic             cargar;
  logic             paso;
  logic             guardar;

  // Datapath strobes decoded from the current state.
  assign cargar  = (estado == REPOSO) && inicio;
  assign paso    = (estado == PASO);
  assign guardar = paso && (cnt == ULTIMO);

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= REPOSO;
      cnt     <= '0;
      listo   <= 1'b1;
      ocupado <= 1'b0;
      valido  <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            estado  <= PASO;
            cnt     <= '0;
            listo   <= 1'b0;
            ocupado <= 1'b1;
          end
        end
        PASO: begin
          cnt <= cnt + UNO;
          // No early exit on a zero multiplier: latency is always K steps.
          if (cnt == ULTIMO) begin
            estado <= FIN;
            valido <= 1'b1;
          end
        end
        FIN: begin
          estado  <= REPOSO;
          listo   <= 1'b1;
          ocupado <= 1'b0;
          valido  <= 1'b0;
        end
        default: begin
          // Unreachable encoding 2'd3: recover to idle.
          estado  <= REPOSO;
          cnt     <= '0;
          listo   <= 1'b1;
          ocupado <= 1'b0;
          valido  <= 1'b0;
        end
      endcase
    end
  end

  camino_datos_der_izq #(
    .K (K)
  ) u_camino_datos (
    .clk      (clk),
    .reset    (reset),
    .cargar   (cargar),
    .paso     (paso),
    .guardar  (guardar),
    .a_valor  (A_valor),
    .b_valor  (B_valor),
    .producto (producto)
  );

endmodule

// File: tb/tb_control_mult_der_izq.sv
// -----------------------------------------------------------------------------
// tb_control_mult_der_izq
//   Self-checking bench for control_mult_der_izq with K=4. Expected results
//   come from plain multiplication; expected timing comes from the
//   REPOSO / K x PASO / FIN cycle sequence.
// -----------------------------------------------------------------------------
module tb_control_mult_der_izq;

  localparam int K = 4;

  logic           clk;
  logic           reset;
  logic           inicio;
  logic [K-1:0]   A_valor;
  logic [K-1:0]   B_valor;
  logic           listo;
  logic           ocupado;
  logic           valido;
  logic [2*K-1:0] producto;

  int             tests;
  int             fallos;
  logic [2*K-1:0] ultimo;

  control_mult_der_izq #(
    .K (K)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
    .A_valor  (A_valor),
    .B_valor  (B_valor),
    .listo    (listo),
    .ocupado  (ocupado),
    .valido   (valido),
    .producto (producto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [63:0] obs,
                           input logic [63:0] esp);
    tests++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  // Called at a falling edge while idle. Runs one full multiplication and
  // returns at the falling edge of the REPOSO cycle after FIN. During the
  // busy cycles the operands are replaced by (a2,b2) and, if requested,
  // inicio is kept asserted to show it is ignored.
  task automatic operar(input logic [K-1:0] a, input logic [K-1:0] b,
                        input logic [K-1:0] a2, input logic [K-1:0] b2,
                        input bit molestar);
    logic [2*K-1:0] esperado;
    esperado = (2*K)'(a) * (2*K)'(b);
    comprobar("listo_antes", listo, 1);
    A_valor = a;
    B_valor = b;
    inicio  = 1'b1;
    @(negedge clk);
    A_valor = a2;
    B_valor = b2;
    inicio  = molestar;
    for (int i = 0; i < K; i++) begin
      comprobar("ocupado_paso", ocupado, 1);
      comprobar("listo_paso", listo, 0);
      comprobar("valido_paso", valido, 0);
      comprobar("producto_estable", producto, ultimo);
      @(negedge clk);
    end
    comprobar("valido_fin", valido, 1);
    comprobar("ocupado_fin", ocupado, 1);
    comprobar("listo_fin", listo, 0);
    comprobar("producto_fin", producto, esperado);
    ultimo = esperado;
    inicio = 1'b0;
    @(negedge clk);
    comprobar("listo_reposo", listo, 1);
    comprobar("valido_reposo", valido, 0);
    comprobar("ocupado_reposo", ocupado, 0);
    comprobar("producto_retenido", producto, ultimo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fallos  = 0;
    ultimo  = '0;
    reset   = 1'b1;
    inicio  = 1'b0;
    A_valor = '0;
    B_valor = '0;
    repeat (2) @(negedge clk);
    comprobar("rst_listo", listo, 1);
    comprobar("rst_ocupado", ocupado, 0);
    comprobar("rst_valido", valido, 0);
    comprobar("rst_producto", producto, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases, including extremes of the operand range.
    operar(4'b1100, 4'b0101, 4'h0, 4'h0, 1'b0);
    operar(4'hF, 4'hF, 4'h1, 4'h2, 1'b0);
    operar(4'h0, 4'h9, 4'hF, 4'hF, 1'b0);
    operar(4'hF, 4'h0, 4'h3, 4'h7, 1'b0);
    // Operands change and inicio stays high while busy: no effect.
    operar(4'd11, 4'd10, 4'd4, 4'd9, 1'b1);

    // inicio held continuously: one result every K+2 cycles.
    A_valor = 4'd9;
    B_valor = 4'd10;
    inicio  = 1'b1;
    for (int i = 1; i <= 3 * (K + 2); i++) begin
      @(negedge clk);
      comprobar("continuo_valido", valido, ((i % (K + 2)) == K + 1) ? 1 : 0);
      if ((i % (K + 2)) == K + 1) begin
        comprobar("continuo_producto", producto, 8'h5A);
      end
      if (i == 3 * (K + 2)) begin
        inicio = 1'b0;
      end
    end
    ultimo = 8'h5A;
    @(negedge clk);
    comprobar("continuo_reposo", listo, 1);

    // Reset in the middle of an operation.
    A_valor = 4'd12;
    B_valor = 4'd9;
    inicio  = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    comprobar("abort_listo", listo, 1);
    comprobar("abort_ocupado", ocupado, 0);
    comprobar("abort_valido", valido, 0);
    comprobar("abort_producto", producto, 0);
    @(negedge clk);
    reset  = 1'b0;
    ultimo = '0;
    operar(4'd12, 4'd9, 4'd0, 4'd0, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 25; n++) begin
      operar(K'($urandom), K'($urandom), K'($urandom), K'($urandom),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fallos);
    $finish;
  end

endmodule

// File: doc/control_mult_der_izq.md
CONTROL_MULT_DER_IZQ -- requirements
Module: control_mult_der_izq

Interface
REQ-001 Parameter K, default 4, SHALL set the operand width in bits (legal range K >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 inicio  input  1  SHALL request a multiplication; it is sampled only while listo=1.
REQ-005 A_valor  input  K  SHALL be the multiplicand, captured on the accepting edge.
REQ-006 B_valor  input  K  SHALL be the multiplier, captured on the accepting edge.
REQ-007 listo  output  1  SHALL be high only in state REPOSO (ready to accept).
REQ-008 ocupado  output  1  SHALL be high in states PASO and FIN.
REQ-009 valido  output  1  SHALL be a one-cycle pulse, high only in state FIN.
REQ-010 producto  output  2K  SHALL be the registered result A_valor*B_valor (unsigned).

Function
REQ-011 The FSM SHALL have exactly three states: REPOSO, PASO, FIN.
REQ-012 REPOSO with inicio=1 SHALL go to PASO on the next edge, capturing A_valor into the 2K-bit multiplicand register (zero-extended) and B_valor into the K-bit multiplier register, and clearing the accumulator and step counter.
REQ-013 REPOSO with inicio=0 SHALL stay in REPOSO with no register change.
REQ-014 Each PASO cycle SHALL add the multiplicand to the accumulator if multiplier bit 0 is 1, shift the multiplicand left by 1, shift the multiplier right by 1 (zero fill), and increment the counter.
REQ-015 PASO SHALL last exactly K cycles; there is no early termination on a zero multiplier.
REQ-016 After the K-th PASO cycle the FSM SHALL go to FIN and load producto from the final accumulator value.
REQ-017 FIN SHALL last one cycle and return to REPOSO unconditionally.
REQ-018 Latency: accepting edge t, valido high in cycle t+K+1; the next start can be accepted in cycle t+K+2.
REQ-019 inicio during PASO or FIN SHALL be ignored, with no queuing.
REQ-020 producto SHALL hold its value from FIN until the next FIN; it SHALL NOT change during PASO.
REQ-021 The accumulator SHALL be 2K bits and SHALL never overflow; the maximum result is (2^K-1)^2.
REQ-022 Operand changes on A_valor/B_valor after the accepting edge SHALL NOT affect the result.
REQ-023 The step counter width SHALL be $clog2(K)+1 bits; the terminal compare SHALL be against K-1 while in PASO.

Reset
REQ-024 Asserting reset SHALL immediately force REPOSO, listo=1, ocupado=0, valido=0, producto=0, and clear the accumulator, operand registers and counter.
REQ-025 Reset asserted mid-operation SHALL abort it with no valido pulse; after deassertion the block SHALL accept a new inicio on the first edge.
REQ-026 No output SHALL be X after reset.

Structure
REQ-027 The state encodings (REPOSO=2'd0, PASO=2'd1, FIN=2'd2) SHALL reside in a shared package/include file together with the default K.
REQ-028 The datapath (multiplicand, multiplier, accumulator, shift/add) SHALL be one sub-module, camino_datos_der_izq, driven by control strobes cargar/paso/guardar from the FSM in control_mult_der_izq.
REQ-029 Illegal state encoding 2'd3 SHALL return to REPOSO on the next edge.

Verification (K=4)
REQ-030 A=4'b1100, B=4'b0101, one-cycle inicio -> valido 5 cycles after accept, producto=8'h3C (60), listo 1 cycle later.
REQ-031 A=4'hF, B=4'hF -> producto=8'hE1 (225); A=4'h0, B=4'h9 -> 8'h00, still K PASO cycles.
REQ-032 inicio held high continuously with A=9, B=10 -> a valido pulse every 6 cycles, producto=8'h5A each time, no missed or extra pulse.
REQ-033 Accept A=11, B=10, then change inputs to A=4, B=9 and pulse inicio during PASO -> producto=8'h6E (110) only; the second request is ignored.
REQ-034 Accept A=12, B=9, assert reset after 2 PASO cycles -> all outputs go to reset values at once, no valido; then A=12, B=9 -> producto=8'h6C (108).
